// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Owns the PC, issues one word request at a
// time over a req/gnt/rvalid handshake and buffers {word, pc} in a DEPTH-entry
// FIFO presented to the decoder with valid/ready. A redirect flushes the FIFO
// and, when a response is still in flight, drains it before refetching.
// Optional feature: define FETCH_PERF_CNT_EN to add the fetch_count port and
// its 32-bit delivered-instruction counter.
module fetch_unit #(
   parameter int             N        = 32,
   parameter logic [N-1:0]   RESET_PC = '0,
   parameter int             DEPTH    = 2
) (
   input  logic         clk,
   input  logic         rst,
   output logic         imem_req,
   output logic [N-1:0] imem_addr,
   input  logic         imem_gnt,
   input  logic         imem_rvalid,
   input  logic [31:0]  imem_rdata,
   input  logic         redirect,
   input  logic [N-1:0] redirect_pc,
   output logic         instr_valid,
   input  logic         instr_ready,
   output logic [31:0]  instruction,
   output logic [N-1:0] instr_pc
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]  fetch_count
`endif
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);
   localparam logic [N-1:0]     ALIGN_MASK = ~N'(3);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,   // nothing outstanding
      S_WAIT  = 2'd1,   // one request outstanding, response will be kept
      S_DRAIN = 2'd2    // one request outstanding, response will be dropped
   } state_t;

   state_t             state_q, state_d;
   logic [N-1:0]       fetch_pc_q, fetch_pc_d;   // next address to request
   logic [N-1:0]       req_pc_q, req_pc_d;       // pc of the outstanding request
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [31:0]        word_q [DEPTH];
   logic [N-1:0]       pc_q   [DEPTH];

   logic               push;
   logic               deq;
   logic               accept;
   logic [CNT_W-1:0]   count_after_push;

   // State register: FSM, PC, FIFO pointers and occupancy
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         fetch_pc_q <= RESET_PC;
         req_pc_q   <= RESET_PC;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         req_pc_q   <= req_pc_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

   // FIFO storage: contents need no reset, the head is qualified by occupancy
   always_ff @(posedge clk) begin
      if (push) begin
         word_q[wr_ptr_q] <= imem_rdata;
         pc_q[wr_ptr_q]   <= req_pc_q;
      end
   end

   // Next-state: handshake progress, FIFO bookkeeping, redirect override
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      req_pc_d   = req_pc_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      push       = 1'b0;
      accept     = imem_req && imem_gnt;

      case (state_q)
         S_IDLE: begin
            if (accept) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (imem_rvalid) begin
               push    = 1'b1;
               state_d = accept ? S_WAIT : S_IDLE;
            end
         end
         S_DRAIN: begin
            if (imem_rvalid) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (accept) begin
         req_pc_d   = fetch_pc_q;
         fetch_pc_d = fetch_pc_q + N'(4);
      end
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (deq)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(deq);

      // Redirect wins over everything: flush, drop any same-cycle response,
      // and drain a response that is still on its way.
      if (redirect) begin
         push       = 1'b0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         fetch_pc_d = redirect_pc & ALIGN_MASK;
         state_d    = (state_q != S_IDLE && !imem_rvalid) ? S_DRAIN : S_IDLE;
      end
   end

   // Outputs: FIFO head, request strobe (WAIT may re-request on the response cycle)
   always_comb begin
      instr_valid      = (count_q != '0);
      instruction      = instr_valid ? word_q[rd_ptr_q] : 32'h0;
      instr_pc         = instr_valid ? pc_q[rd_ptr_q] : '0;
      imem_addr        = fetch_pc_q;
      deq              = instr_valid && instr_ready;
      count_after_push = count_q + CNT_W'(1) - CNT_W'(deq);
      imem_req         = 1'b0;
      if (!rst && !redirect) begin
         case (state_q)
            S_IDLE:  imem_req = (count_q < DEPTH_C);
            S_WAIT:  imem_req = imem_rvalid && (count_after_push < DEPTH_C);
            default: imem_req = 1'b0;
         endcase
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_count_q, fetch_count_d;

   // Delivered-instruction counter: survives redirects, cleared only by reset
   always_comb begin
      fetch_count_d = fetch_count_q + 32'(deq);
   end

   // Counter register
   always_ff @(posedge clk) begin
      if (rst) fetch_count_q <= '0;
      else     fetch_count_q <= fetch_count_d;
   end

   assign fetch_count = fetch_count_q;
`endif

endmodule
